// File: rtl/pwm_fader.sv
// pwm_fader: steps a PWM duty value toward a target or breathes it between 0 and a peak
module pwm_fader #(
  parameter int unsigned STEP_TICKS       = 100000,
  parameter logic [7:0]  RESET_DUTY_CYCLE = 8'd50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cmd_target,
  input  logic       cmd_breathe,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       stop,
  output logic [7:0] duty_cycle,
  output logic       duty_valid,
  output logic       busy,
  output logic       done
);
  typedef enum logic [1:0] {IDLE, RAMP, BR_UP, BR_DOWN} state_t;
  localparam logic [23:0] RELOAD = 24'(STEP_TICKS - 1);
  state_t      state_q, state_d;
  logic [23:0] tick_q, tick_d;
  logic [7:0]  duty_q, duty_d, tgt_q, tgt_d, tgt_c;
  logic        dv_q, dv_d, done_q, done_d, accept, step;
  assign cmd_ready  = !stop && state_q != RAMP;
  assign accept     = cmd_valid && cmd_ready;
  assign tgt_c      = cmd_target > 8'd100 ? 8'd100 : cmd_target;
  assign step       = state_q != IDLE && tick_q == 24'd0;
  assign duty_cycle = duty_q;
  assign duty_valid = dv_q;
  assign done       = done_q;
  assign busy       = state_q != IDLE;
  // next state: stop wins, then a new command, then the periodic duty step
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    duty_d  = duty_q;
    tgt_d   = tgt_q;
    dv_d    = 1'b0;
    done_d  = 1'b0;
    if (stop) begin
      state_d = IDLE;
    end else if (accept) begin
      tgt_d  = tgt_c;
      tick_d = RELOAD;
      if (!cmd_breathe || tgt_c == 8'd0) begin
        state_d = tgt_c == duty_q ? IDLE : RAMP;
        done_d  = tgt_c == duty_q;
      end else begin
        state_d = duty_q < tgt_c ? BR_UP : BR_DOWN;
      end
    end else if (state_q != IDLE) begin
      tick_d = step ? RELOAD : tick_q - 24'd1;
      if (step) begin
        dv_d   = 1'b1;
        duty_d = (state_q == BR_UP || (state_q == RAMP && duty_q < tgt_q)) ? duty_q + 8'd1 : duty_q - 8'd1;
        if (state_q == RAMP && duty_d == tgt_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
        if (state_q == BR_UP && duty_d == tgt_q) state_d = BR_DOWN;
        if (state_q == BR_DOWN && duty_d == 8'd0) state_d = BR_UP;
      end
    end
  end
  // state register with asynchronous reset to the reset duty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= RELOAD;
      duty_q  <= RESET_DUTY_CYCLE;
      tgt_q   <= RESET_DUTY_CYCLE;
      dv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      duty_q  <= duty_d;
      tgt_q   <= tgt_d;
      dv_q    <= dv_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: doc/pwm_fader.md
PWM_FADER -- requirements
Module: pwm_fader

Interface
REQ-001 SHALL have parameter STEP_TICKS, default 100000, 24-bit clock cycles between duty steps, legal range >= 1.
REQ-002 SHALL have parameter RESET_DUTY_CYCLE, default 50, 8-bit duty value (%) loaded on reset.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port cmd_target  input  8  requested duty (%), ramp endpoint or breathe peak.
REQ-006 SHALL have port cmd_breathe  input  1  0 = single ramp, 1 = continuous breathe.
REQ-007 SHALL have port cmd_valid  input  1  command present.
REQ-008 SHALL have port cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at rising edge.
REQ-009 SHALL have port stop  input  1  abort current activity, hold duty.
REQ-010 SHALL have port duty_cycle  output  8  duty value for downstream pwm stage.
REQ-011 SHALL have port duty_valid  output  1  one-cycle strobe, duty_cycle changed.
REQ-012 SHALL have port busy  output  1  high in any non-IDLE state.
REQ-013 SHALL have port done  output  1  one-cycle pulse, single ramp reached target.

Function
REQ-014 SHALL implement states IDLE, RAMP, BR_UP, BR_DOWN.
REQ-015 SHALL drive cmd_ready = !stop && (state != RAMP), combinationally.
REQ-016 SHALL clamp an accepted cmd_target > 100 to 100 before storage.
REQ-017 On accept with cmd_breathe=0, SHALL enter RAMP and reload tick counter to STEP_TICKS-1.
REQ-018 On accept with cmd_breathe=1 and clamped target > 0, SHALL enter BR_UP if duty_cycle < target, else BR_DOWN, and reload tick counter.
REQ-019 On accept with cmd_breathe=1 and target 0, SHALL behave as a single ramp to 0.
REQ-020 Accept during BR_UP/BR_DOWN SHALL preempt breathing; the new command starts from the current duty_cycle.
REQ-021 In non-IDLE states, tick counter SHALL decrement each cycle, and at 0 reload STEP_TICKS-1 and issue one step; first step occurs STEP_TICKS cycles after accept.
REQ-022 Each step SHALL change duty_cycle by exactly 1 and assert duty_valid for the following cycle; no step SHALL move duty outside 0..100.
REQ-023 RAMP step SHALL move duty toward target; on the step reaching target, SHALL return to IDLE and assert done in the same cycle as that duty_valid.
REQ-024 Ramp accepted with target equal to current duty SHALL produce no duty_valid, assert done the cycle after accept, and return to IDLE.
REQ-025 BR_UP step reaching target SHALL switch to BR_DOWN; BR_DOWN step reaching 0 SHALL switch to BR_UP; reversal happens on the limit step with no dwell; done never asserts in breathe.
REQ-026 stop high at a rising edge SHALL force IDLE, hold duty_cycle, suppress that edge's step, and assert no done; stop overrides a simultaneous cmd_valid, which is not accepted.
REQ-027 IDLE SHALL hold duty_cycle constant with duty_valid low.
REQ-028 duty_valid and done SHALL be registered outputs.

Reset
REQ-029 While rst high, SHALL force state IDLE, duty_cycle = RESET_DUTY_CYCLE, duty_valid=0, done=0, busy=0, tick counter = STEP_TICKS-1, stored target = RESET_DUTY_CYCLE.
REQ-030 Reset asserted mid-ramp or mid-breathe SHALL abort immediately without done; after deassertion no duty_valid SHALL occur until a new command is accepted.

Verification (STEP_TICKS=4, RESET_DUTY_CYCLE=50)
REQ-031 Reset, then ramp to 53 -> duty_valid at 4, 8, 12 cycles after accept with duty 51, 52, 53; done with the third; busy low afterward.
REQ-032 Ramp to 200 from 98 -> target clamped; duty 99, 100, done; duty never exceeds 100.
REQ-033 Breathe with target 52 from duty 50 -> sequence 51, 52, 51, 50, ..., 1, 0, 1, 2, ... every 4 cycles; no done.
REQ-034 Breathe running, ramp command to 10 -> accepted next edge, duty decreases monotonically to 10, done; cmd_ready low during ramp.
REQ-035 stop and cmd_valid high on same edge mid-ramp -> IDLE, duty held, no done, command not accepted.
REQ-036 Ramp to 50 from 50 -> no duty_valid, done one cycle after accept; async rst mid-ramp -> duty returns to 50 without waiting for a clock edge.
